// File: rtl/number_to_ascii_stream_if.sv
// Handshake bundle between a number source/character sink
// and the binary-to-ASCII digit streamer.
interface number_to_ascii_stream_if #(
  parameter int BIN_W = 14
);
  logic             START;
  logic [BIN_W-1:0] VALUE;
  logic             BUSY;
  logic             CHAR_VALID;
  logic [7:0]       CHAR;
  logic             CHAR_READY;
  logic             CHAR_LAST;
  logic             OVERFLOW;

  modport master (
    output START,
    output VALUE,
    output CHAR_READY,
    input  BUSY,
    input  CHAR_VALID,
    input  CHAR,
    input  CHAR_LAST,
    input  OVERFLOW
  );

  modport slave (
    input  START,
    input  VALUE,
    input  CHAR_READY,
    output BUSY,
    output CHAR_VALID,
    output CHAR,
    output CHAR_LAST,
    output OVERFLOW
  );
endinterface

// File: rtl/number_to_ascii_stream.sv
// Serial double-dabble converter that streams a binary value
// as DIGITS ASCII characters, most significant first.
module number_to_ascii_stream #(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic                     CLK,
  input logic                     RESETN,
  number_to_ascii_stream_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_EMIT
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               lead_q, lead_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         char_q, char_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic [BCD_W-1:0]   dab;
  logic [3:0]         digit;
  logic [7:0]         ch;
  logic               adv;

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: convert for BIN_W steps, emit until last accept
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.START) state_d = S_CONV;
      S_CONV: if (cnt_q == CNT_W'(1)) state_d = S_EMIT;
      S_EMIT: if (valid_q && bus.CHAR_READY && last_q)
                state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Add-3 correction and current character selection
  always_comb begin
    dab = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        dab[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    digit = bcd_q[BCD_W-1 -: 4];
    ch    = {4'h3, digit};
    if (ovf_q)
      ch = 8'h2D;
    else if (BLANK_LZ && lead_q && digit == 4'd0
             && idx_q != '0)
      ch = 8'h20;
    adv = !valid_q || bus.CHAR_READY;
  end

  // Datapath next values
  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lead_d  = lead_q;
    ovf_d   = ovf_q;
    char_d  = char_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          bin_d  = bus.VALUE;
          bcd_d  = '0;
          cnt_d  = CNT_W'(BIN_W);
          idx_d  = IDX_W'(DIGITS - 1);
          lead_d = 1'b1;
          ovf_d  = 64'(bus.VALUE) >= LIMIT;
        end
      end
      S_CONV: begin
        {bcd_d, bin_d} = {dab, bin_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_EMIT: begin
        if (adv) begin
          if (valid_q && last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            char_d  = 8'h00;
            ovf_d   = 1'b0;
            bcd_d   = '0;
          end else begin
            char_d  = ch;
            valid_d = 1'b1;
            last_d  = (idx_q == '0);
            bcd_d   = bcd_q << 4;
            lead_d  = lead_q && (digit == 4'd0);
            if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      lead_q  <= 1'b0;
      ovf_q   <= 1'b0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lead_q  <= lead_d;
      ovf_q   <= ovf_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.BUSY       = (state_q != S_IDLE);
  assign bus.CHAR       = char_q;
  assign bus.CHAR_VALID = valid_q;
  assign bus.CHAR_LAST  = last_q;
  assign bus.OVERFLOW   = ovf_q && (state_q == S_EMIT);
endmodule

// File: tb/tb_number_to_ascii_stream.sv
// Randomized and directed bench for the ASCII digit streamer,
// two configurations checked against a decimal reference.
module tb_number_to_ascii_stream;
  logic        clk = 1'b0;
  logic        rstn_a = 1'b0;
  logic        rstn_b = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] value = '0;
  int          sel = 0;
  int          checks = 0;
  int          failures = 0;

  logic       m_valid, m_last, m_ovf, m_busy;
  logic [7:0] m_char;

  logic [7:0] exp_c [8];
  bit         exp_ov;

  always #5 clk = ~clk;

  number_to_ascii_stream_if #(.BIN_W(14)) bus_a ();
  number_to_ascii_stream_if #(.BIN_W(20)) bus_b ();

  assign bus_a.START      = start && (sel == 0);
  assign bus_a.VALUE      = value[13:0];
  assign bus_a.CHAR_READY = ready && (sel == 0);
  assign bus_b.START      = start && (sel == 1);
  assign bus_b.VALUE      = value[19:0];
  assign bus_b.CHAR_READY = ready && (sel == 1);

  number_to_ascii_stream dut_a (
    .CLK    (clk),
    .RESETN (rstn_a),
    .bus    (bus_a)
  );

  number_to_ascii_stream #(
    .BIN_W    (20),
    .DIGITS   (6),
    .BLANK_LZ (1'b0)
  ) dut_b (
    .CLK    (clk),
    .RESETN (rstn_b),
    .bus    (bus_b)
  );

  always_comb begin
    if (sel == 0) begin
      m_valid = bus_a.CHAR_VALID;
      m_last  = bus_a.CHAR_LAST;
      m_ovf   = bus_a.OVERFLOW;
      m_busy  = bus_a.BUSY;
      m_char  = bus_a.CHAR;
    end else begin
      m_valid = bus_b.CHAR_VALID;
      m_last  = bus_b.CHAR_LAST;
      m_ovf   = bus_b.OVERFLOW;
      m_busy  = bus_b.BUSY;
      m_char  = bus_b.CHAR;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal digits straight from division, per the
  // blanking/overflow rules.
  task automatic model(input longint unsigned v,
                       input int nd, input bit bl);
    longint unsigned lim, p;
    int d;
    bit lead;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    exp_ov = (v >= lim);
    lead = 1'b1;
    for (int k = 0; k < nd; k++) begin
      p = 1;
      for (int i = 0; i < nd - 1 - k; i++) p = p * 10;
      d = int'((v / p) % 10);
      if (exp_ov)
        exp_c[k] = 8'h2D;
      else if (bl && lead && d == 0 && k != nd - 1)
        exp_c[k] = 8'h20;
      else
        exp_c[k] = 8'h30 + 8'(d);
      if (d != 0) lead = 1'b0;
    end
  endtask

  // rmode: 0 ready high, 1 random, 2 fixed stall pattern
  task automatic run_frame(input int s,
                           input int unsigned v,
                           input int rmode,
                           input bit hold);
    int nd, bw, got, pidx;
    bit bl, seen, done, r, pstall;
    logic [7:0] pc;
    logic pv, pl;
    bit [7:0] pat;
    pat = 8'b1011_0100;
    sel = s;
    nd = (s == 1) ? 6 : 4;
    bw = (s == 1) ? 20 : 14;
    bl = (s == 0);
    model(longint'(v), nd, bl);
    got = 0; pidx = 0;
    seen = 0; done = 0; pstall = 0;
    pc = '0; pv = 0; pl = 0;
    @(negedge clk);
    value = v;
    start = 1'b1;
    ready = (rmode == 0);
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      start = hold;
      if (j == 0) check("busy_start", m_busy, 1);
      if (!seen && m_valid) begin
        seen = 1;
        check("latency", j, bw + 1);
      end
      if (pstall) begin
        check("stall_char", m_char, pc);
        check("stall_valid", m_valid, pv);
        check("stall_last", m_last, pl);
      end
      r = 1'b1;
      if (rmode == 1) r = ($urandom_range(0, 3) != 0);
      if (rmode == 2) begin
        r = 1'b0;
        if (seen) begin
          r = (pidx < 8) ? pat[pidx] : 1'b1;
          pidx++;
        end
      end
      ready = r;
      if (m_valid && r) begin
        check("char", m_char, exp_c[got]);
        check("last", m_last, got == nd - 1);
        check("ovf", m_ovf, exp_ov);
        check("busy_emit", m_busy, 1);
        got++;
        if (got == nd) begin
          done = 1;
          break;
        end
      end
      pstall = m_valid && !r;
      pc = m_char; pv = m_valid; pl = m_last;
    end
    start = 1'b0;
    check("frame_done", done, 1);
    @(negedge clk);
    check("busy_end", m_busy, 0);
    check("valid_end", m_valid, 0);
    check("last_end", m_last, 0);
    check("ovf_end", m_ovf, 0);
    ready = 1'b0;
  endtask

  initial begin
    #7;
    check("rst_a_busy", bus_a.BUSY, 0);
    check("rst_a_valid", bus_a.CHAR_VALID, 0);
    check("rst_a_char", bus_a.CHAR, 0);
    check("rst_a_last", bus_a.CHAR_LAST, 0);
    check("rst_a_ovf", bus_a.OVERFLOW, 0);
    check("rst_b_busy", bus_b.BUSY, 0);
    check("rst_b_valid", bus_b.CHAR_VALID, 0);
    @(negedge clk);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 1234, 0, 0);
    run_frame(0, 7, 0, 0);
    run_frame(0, 0, 0, 0);
    run_frame(0, 9050, 0, 0);
    run_frame(0, 4080, 2, 0);
    run_frame(0, 12000, 0, 0);
    run_frame(0, 9999, 0, 0);
    run_frame(0, 5555, 0, 1);
    repeat (3) begin
      @(negedge clk);
      check("no_refire", m_valid, 0);
    end

    sel = 0;
    @(negedge clk);
    value = 1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (m_valid) begin
          hit = 1;
          break;
        end
      end
      check("rst_wait", hit, 1);
    end
    #3;
    rstn_a = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_char", m_char, 0);
    check("mid_rst_busy", m_busy, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_ovf", m_ovf, 0);
    @(negedge clk);
    rstn_a = 1'b1;
    ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", m_valid, 0);
    end
    ready = 1'b0;
    run_frame(0, 42, 0, 0);

    run_frame(1, 7, 0, 0);
    run_frame(1, 1000000, 0, 0);

    for (int n = 0; n < 20; n++)
      run_frame(0, $urandom_range(0, 16383), 1, 0);
    for (int n = 0; n < 10; n++)
      run_frame(1, $urandom_range(0, 1048575), 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
